// File: rtl/wbf_pkg.sv
// rtl/wbf_pkg.sv - shared state encodings and config bit indices for the weight buffer
package wbf_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    CFG  = 3'b001,
    WORK = 3'b010
  } wbf_state_e;

  localparam int KEEP  = 0;
  localparam int NOCHK = 1;

endpackage

// File: rtl/wbf_ram.sv
// rtl/wbf_ram.sv - weight store with one write port and one registered, enabled read port
module wbf_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_adr,
  input  logic [DATA_WIDTH-1:0] i_wr_dat,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_adr,
  output logic [DATA_WIDTH-1:0] o_rd_dat
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_dat;

  // Read output holds between enables, matching a macro's behaviour.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_adr] <= i_wr_dat;
    if (i_rd_en) r_rd_dat <= r_mem[i_rd_adr];
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/wei_buf_rsp.sv
// rtl/wei_buf_rsp.sv - weight buffer: GLB fill stream in, single-address reads out to the weight cache
import wbf_pkg::*;

module wei_buf_rsp #(
  parameter int DATA_WIDTH     = 8,
  parameter int WEI_ADDR_WIDTH = 8,
  parameter int ISA_WIDTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      TOPWBF_CfgVld,
  input  logic [ISA_WIDTH-1:0]      TOPWBF_CfgISA,
  output logic                      WBFTOP_CfgRdy,
  input  logic                      GLBWBF_DatVld,
  input  logic [DATA_WIDTH-1:0]     GLBWBF_Dat,
  output logic                      WBFGLB_DatRdy,
  input  logic                      WCAWBF_AdrVld,
  input  logic [WEI_ADDR_WIDTH-1:0] WCAWBF_Adr,
  output logic                      WBFWCA_AdrRdy,
  output logic                      WBFWCA_DatVld,
  output logic [DATA_WIDTH-1:0]     WBFWCA_Dat,
  input  logic                      WCAWBF_DatRdy
);

  localparam int DEPTH = 2 ** WEI_ADDR_WIDTH;
  localparam logic [WEI_ADDR_WIDTH:0] CNT_FULL = (WEI_ADDR_WIDTH+1)'(DEPTH);

  wbf_state_e                r_state;
  logic [ISA_WIDTH-1:0]      r_cfg_isa;
  logic                      r_cfg_rdy;
  logic [WEI_ADDR_WIDTH:0]   r_wr_cnt;
  logic                      r_out_vld;
  logic                      r_dat_clr;
  logic [DATA_WIDTH-1:0]     w_ram_dat;
  logic                      w_work;
  logic                      w_fill_rdy;
  logic                      w_fill_hs;
  logic                      w_addr_ok;
  logic                      w_adr_rdy;
  logic                      w_adr_hs;

  assign w_work     = (r_state == WORK);
  assign w_fill_rdy = w_work && (r_wr_cnt != CNT_FULL);
  assign w_fill_hs  = w_fill_rdy && GLBWBF_DatVld;
  // Old count is used, so the slot being written this cycle is not yet readable.
  assign w_addr_ok  = r_cfg_isa[NOCHK] || ({1'b0, WCAWBF_Adr} < r_wr_cnt);
  assign w_adr_rdy  = w_work && !TOPWBF_CfgVld && w_addr_ok && (!r_out_vld || WCAWBF_DatRdy);
  assign w_adr_hs   = w_adr_rdy && WCAWBF_AdrVld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cfg_isa <= '0;
      r_cfg_rdy <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (TOPWBF_CfgVld) begin
          r_state   <= CFG;
          r_cfg_isa <= TOPWBF_CfgISA;
          r_cfg_rdy <= 1'b0;
        end
        CFG:  r_state <= WORK;
        WORK: if (TOPWBF_CfgVld) begin
          r_state   <= IDLE;
          r_cfg_rdy <= 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          r_cfg_rdy <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
    end else if (r_state == CFG && !r_cfg_isa[KEEP]) begin
      r_wr_cnt <= '0;
    end else if (w_fill_hs) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
    end
  end

  // r_dat_clr stands in for clearing the RAM read register, which has no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_dat_clr <= 1'b1;
    end else if (w_work && !TOPWBF_CfgVld) begin
      if (w_adr_hs) begin
        r_out_vld <= 1'b1;
        r_dat_clr <= 1'b0;
      end else if (r_out_vld && WCAWBF_DatRdy) begin
        r_out_vld <= 1'b0;
      end
    end else begin
      r_out_vld <= 1'b0;
      r_dat_clr <= 1'b1;
    end
  end

  wbf_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(WEI_ADDR_WIDTH)
  ) u_ram (
    .clk      (clk),
    .i_wr_en  (w_fill_hs),
    .i_wr_adr (r_wr_cnt[WEI_ADDR_WIDTH-1:0]),
    .i_wr_dat (GLBWBF_Dat),
    .i_rd_en  (w_adr_hs),
    .i_rd_adr (WCAWBF_Adr),
    .o_rd_dat (w_ram_dat)
  );

  assign WBFTOP_CfgRdy = r_cfg_rdy;
  assign WBFGLB_DatRdy = w_fill_rdy;
  assign WBFWCA_AdrRdy = w_adr_rdy;
  assign WBFWCA_DatVld = r_out_vld;
  assign WBFWCA_Dat    = r_dat_clr ? '0 : w_ram_dat;

endmodule

// File: doc/wei_buf_rsp.md
# wei_buf_rsp

Weight buffer: on-chip weight store between the global buffer (GLB) fill stream and the weight cache read port. It accepts sequential weight bytes from GLB, then answers single-address read requests from the weight cache with one-cycle read latency. Data is returned through a valid/ready output register at full throughput, one read per cycle. A configuration FSM shares the IDLE/CFG/WORK protocol of the other PE-array blocks.

## Interface
- DATA_WIDTH, 8, weight width.
- WEI_ADDR_WIDTH, 8, address width; DEPTH = 2**WEI_ADDR_WIDTH entries.
- ISA_WIDTH, 2, config word width.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- TOPWBF_CfgVld  in  1  config strobe; also the WORK exit request.
- TOPWBF_CfgISA  in  ISA_WIDTH  config word: bit0 keep (retain contents/count), bit1 nochk (skip fill check).
- WBFTOP_CfgRdy  out  1  high in IDLE.
- GLBWBF_DatVld  in  1  fill data valid.
- GLBWBF_Dat  in  DATA_WIDTH  fill data.
- WBFGLB_DatRdy  out  1  fill ready.
- WCAWBF_AdrVld  in  1  read address valid.
- WCAWBF_Adr  in  WEI_ADDR_WIDTH  read address.
- WBFWCA_AdrRdy  out  1  read address ready.
- WBFWCA_DatVld  out  1  read data valid.
- WBFWCA_Dat  out  DATA_WIDTH  read data.
- WCAWBF_DatRdy  in  1  read data ready.

## Operation
- Reset: state IDLE, cfg_isa 0, wr_cnt 0, out_vld 0, out_dat 0. WBFTOP_CfgRdy is 1; every other output is 0. RAM contents are not reset.
- FSM transitions:
  - IDLE to CFG on TOPWBF_CfgVld; cfg_isa captures TOPWBF_CfgISA in the same edge.
  - CFG to WORK unconditionally.
  - WORK to IDLE on TOPWBF_CfgVld.
- In CFG, wr_cnt is cleared to 0 unless cfg_isa.keep is set, in which case it is held.
- Fill:
  - WBFGLB_DatRdy = WORK & (wr_cnt != DEPTH).
  - On a fill handshake, RAM[wr_cnt] is written with GLBWBF_Dat and wr_cnt increments.
  - wr_cnt is WEI_ADDR_WIDTH+1 bits wide, saturates at DEPTH and never wraps.
- Read acceptance:
  - addr_ok = nochk | (WCAWBF_Adr < wr_cnt), compared using the wr_cnt value before any same-cycle write.
  - WBFWCA_AdrRdy = WORK & !TOPWBF_CfgVld & addr_ok & (!out_vld | WCAWBF_DatRdy).
- Read return:
  - On an address handshake, out_dat takes RAM[WCAWBF_Adr] and out_vld is set at the next edge.
  - Otherwise, a data handshake (out_vld & WCAWBF_DatRdy) clears out_vld.
  - out_dat holds stable while out_vld & !WCAWBF_DatRdy.
  - WBFWCA_DatVld = out_vld; WBFWCA_Dat = out_dat.
- Simultaneous events:
  - A fill write and a read of a different address in the same cycle are both serviced.
  - A read of the address being written is refused that cycle, because addr_ok uses the old wr_cnt; it is accepted in the next cycle.
  - A data handshake and a new address handshake in the same cycle keep out_vld = 1 and load the new data (back-to-back).
- Leaving WORK: out_vld and out_dat are cleared in IDLE, so pending return data is dropped. wr_cnt is held in IDLE.

## Timing
- Read latency: data is valid the cycle after the address handshake; the RAM uses registered read.
- Throughput: one read per cycle when WCAWBF_DatRdy stays high; one fill per cycle concurrently.
- Backpressure: while out_vld is held because WCAWBF_DatRdy is low, AdrRdy is low and at most one read is outstanding. This matches the weight cache's single s2 address register.
- Full: after DEPTH fills, WBFGLB_DatRdy stays low until the next CFG without keep.
- Empty: with wr_cnt = 0 and nochk = 0, AdrRdy stays low for every address.
- Reset mid-operation: all state returns to reset values asynchronously; outputs are at reset values in the same cycle.

## Structure
- Shared package wbf_pkg holds:
  - state encodings IDLE=3'b000, CFG=3'b001, WORK=3'b010;
  - ISA bit indices KEEP=0, NOCHK=1.
- Sub-module wbf_ram: DEPTH x DATA_WIDTH array with one synchronous write port, one registered read port and a read-enable input. It can later be swapped for a foundry SRAM macro.
- Top level contains the FSM, wr_cnt, the acceptance logic and the output register.

## Test plan
- Fill and read: config ISA=0, fill 0x10..0x1F into addresses 0..15, read addresses 0..15 with DatRdy=1 → DatVld every cycle from 1 cycle after the first AdrRdy, data 0x10..0x1F in order, no gaps.
- Fill hazard: after 4 fills, request address 4 → AdrRdy low; on the 5th fill, AdrRdy rises the following cycle and data equals the 5th fill byte. With ISA=2 (nochk), address 200 is accepted immediately.
- Backpressure: DatRdy low for 3 cycles with DatVld high → Dat stable, AdrRdy low. DatRdy rising with AdrVld high gives back-to-back handshakes.
- Full: fill 256 bytes → WBFGLB_DatRdy low from the cycle after the 256th handshake. Reconfigure with ISA=1 (keep) → data retained and reads of 255 accepted. Reconfigure with ISA=0 → wr_cnt is 0 and reads are blocked.
- Abort: CfgVld in WORK while DatVld is held → AdrRdy low that cycle, FSM goes to IDLE, DatVld is 0 the next cycle, CfgRdy is 1.
- Async reset mid-fill → all outputs at reset values immediately, and the FSM requires a new config before any further fill or read is accepted.
